// File: rtl/pixel_loader_pkg.sv
// Shared types and constants for the HPS pixel loader.
// Optional RAM readback verification is enabled by PIXEL_LOADER_READBACK_EN.
package pixel_loader_pkg;

    localparam int unsigned DEF_H_RES = 320;
    localparam int unsigned DEF_V_RES = 240;

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned CNT_W  = ADDR_W + 1;   // one spare bit so a 2^18-pixel frame can read as full
    localparam int unsigned ROW_W  = 16;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned STAT_W = 4;

    localparam int unsigned CTRL_REQ = 0;
    localparam int unsigned CTRL_FS  = 1;

    localparam int unsigned ST_ACK  = 0;
    localparam int unsigned ST_BUSY = 1;
    localparam int unsigned ST_DONE = 2;
    localparam int unsigned ST_ERR  = 3;

    localparam logic [3:0] RAM_BE = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
`ifdef PIXEL_LOADER_READBACK_EN
        S_RD_ISSUE,
        S_RD_CHECK,
`endif
        S_ACK
    } state_t;

endpackage

// File: rtl/pixel_addr_counter.sv
// Raster-order col/row/address counters for the pixel loader.
// Address is a free-running increment; col/row track position for reporting and frame_done.
module pixel_addr_counter
    import pixel_loader_pkg::*;
#(
    parameter int unsigned H_RES = DEF_H_RES,
    parameter int unsigned V_RES = DEF_V_RES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [CNT_W-1:0] address,
    output logic             frame_done,
    output logic             full_c
);

    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(H_RES * V_RES);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

    logic [CNT_W-1:0] col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            address    <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            address    <= '0;
            frame_done <= 1'b0;
        end else if (advance) begin
            address <= address + CNT_W'(1);
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
                if (row == ROW_LAST) begin
                    frame_done <= 1'b1;
                end
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    assign full_c = !(address < TOTAL);

endmodule

// File: rtl/pixel_loader.sv
// Toggle-handshake responder that writes HPS-posted pixels into image RAM in raster order.
// Define PIXEL_LOADER_READBACK_EN to re-read and verify each written word.
module pixel_loader
    import pixel_loader_pkg::*;
#(
    parameter int unsigned H_RES = DEF_H_RES,
    parameter int unsigned V_RES = DEF_V_RES
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic [CTRL_W-1:0] pix_ctrl,
    output logic [STAT_W-1:0] pix_status,
    output logic [ROW_W-1:0]  pix_row,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_clken,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic [3:0]        ram_byteenable,
    input  logic [31:0]       ram_readdata
);

    state_t state, state_nx;

    logic [CTRL_W-1:0] ctrl_q;
    logic              fs_prev, fs_pend, ack, busy, err, wr_flag;
    logic [PIX_W-1:0]  pix_q;
    logic              cs_q, wr_q;
    logic [3:0]        be_q;

    logic              fs_pend_d, ack_d, busy_d, err_d, wr_flag_d, cs_d, wr_d;
    logic [PIX_W-1:0]  pix_d;
    logic [3:0]        be_d;

    logic              fs_rise_c, pend_c, fs_apply_c, cnt_clear_c, cnt_adv_c, full_c;
    logic              frame_done;
    logic [CNT_W-1:0]  addr;
    logic              unused_bits;

    assign fs_rise_c  = ctrl_q[CTRL_FS] & ~fs_prev;
    assign pend_c     = ctrl_q[CTRL_REQ] != ack;
    assign fs_apply_c = (state == S_IDLE) && (fs_rise_c || fs_pend);

    pixel_addr_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_cnt (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .clear      (cnt_clear_c),
        .advance    (cnt_adv_c),
        .row        (pix_row),
        .address    (addr),
        .frame_done (frame_done),
        .full_c     (full_c)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A frame_start being applied takes the IDLE cycle; the request waits one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!fs_apply_c && pend_c) begin
                    state_nx = full_c ? S_ACK : S_WRITE;
                end
            end
`ifdef PIXEL_LOADER_READBACK_EN
            S_WRITE:    state_nx = S_RD_ISSUE;
            S_RD_ISSUE: state_nx = S_RD_CHECK;
            S_RD_CHECK: state_nx = S_ACK;
`else
            S_WRITE:    state_nx = S_ACK;
`endif
            S_ACK:      state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        fs_pend_d   = fs_pend;
        ack_d       = ack;
        err_d       = err;
        wr_flag_d   = wr_flag;
        pix_d       = pix_q;
        cs_d        = 1'b0;
        wr_d        = 1'b0;
        cnt_clear_c = 1'b0;
        cnt_adv_c   = 1'b0;

        if (fs_apply_c) begin
            cnt_clear_c = 1'b1;
            err_d       = 1'b0;
            fs_pend_d   = 1'b0;
        end else if (fs_rise_c) begin
            fs_pend_d = 1'b1;
        end

        // RAM strobes are registered from the state being entered.
        case (state_nx)
            S_WRITE: begin
                cs_d = 1'b1;
                wr_d = 1'b1;
            end
`ifdef PIXEL_LOADER_READBACK_EN
            S_RD_ISSUE: cs_d = 1'b1;
`endif
            default: ;
        endcase

        case (state)
            S_IDLE: begin
                if (state_nx == S_WRITE) begin
                    pix_d     = pix_data;
                    wr_flag_d = 1'b1;
                end else if (state_nx == S_ACK) begin
                    wr_flag_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
`ifdef PIXEL_LOADER_READBACK_EN
            S_RD_CHECK: begin
                if (ram_readdata[PIX_W-1:0] != pix_q) begin
                    err_d = 1'b1;
                end
            end
`endif
            S_ACK: begin
                ack_d     = ~ack;
                cnt_adv_c = wr_flag;
            end
            default: ;
        endcase

        be_d   = cs_d ? RAM_BE : 4'b0000;
        busy_d = (state_nx != S_IDLE) || (pix_ctrl[CTRL_REQ] != ack_d);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ctrl_q  <= '0;
            fs_prev <= 1'b0;
            fs_pend <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            wr_flag <= 1'b0;
            pix_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
        end else begin
            ctrl_q  <= pix_ctrl;
            fs_prev <= ctrl_q[CTRL_FS];
            fs_pend <= fs_pend_d;
            ack     <= ack_d;
            busy    <= busy_d;
            err     <= err_d;
            wr_flag <= wr_flag_d;
            pix_q   <= pix_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        pix_status          = '0;
        pix_status[ST_ACK]  = ack;
        pix_status[ST_BUSY] = busy;
        pix_status[ST_DONE] = frame_done;
        pix_status[ST_ERR]  = err;
    end

    assign ram_address    = addr[ADDR_W-1:0];
    assign ram_clken      = cs_q;
    assign ram_chipselect = cs_q;
    assign ram_write      = wr_q;
    assign ram_writedata  = {8'h00, pix_q};
    assign ram_byteenable = be_q;

    assign unused_bits = ^{ram_readdata, ctrl_q[3:2], addr[CNT_W-1]};

endmodule

// File: tb/tb_pixel_loader.sv
// Directed self-checking bench for pixel_loader on a reduced 16x4 frame.
// Honours PIXEL_LOADER_READBACK_EN for latency and readback checks.
module tb_pixel_loader;
    import pixel_loader_pkg::*;

    localparam int unsigned TB_H = 16;
    localparam int unsigned TB_V = 4;
`ifdef PIXEL_LOADER_READBACK_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [23:0] pix_data;
    logic [3:0]  pix_ctrl;
    logic [3:0]  pix_status;
    logic [15:0] pix_row;
    logic [17:0] ram_address;
    logic        ram_clken, ram_chipselect, ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_readdata;

    int tests = 0;
    int fails = 0;

    logic        req = 1'b0;
    logic        corrupt = 1'b0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [17:0] last_addr;
    logic [31:0] last_data;
    logic [3:0]  last_be;
    logic [31:0] mem [64];
    int          lat, wcyc, wc_before;

    pixel_loader #(.H_RES(TB_H), .V_RES(TB_V)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .pix_data       (pix_data),
        .pix_ctrl       (pix_ctrl),
        .pix_status     (pix_status),
        .pix_row        (pix_row),
        .ram_address    (ram_address),
        .ram_clken      (ram_clken),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_readdata   (ram_readdata)
    );

    always #5 clk_clk = ~clk_clk;

    // Image RAM model with 1-cycle read latency; optional bit-5 read corruption.
    always @(posedge clk_clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                mem[ram_address[5:0]] <= ram_writedata;
                wr_count  = wr_count + 1;
                last_addr = ram_address;
                last_data = ram_writedata;
                last_be   = ram_byteenable;
            end else begin
                rd_count = rd_count + 1;
                ram_readdata <= mem[ram_address[5:0]] ^ (corrupt ? 32'h20 : 32'h0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Post a pixel and wait (bounded) for the ack toggle; called #1 after a posedge.
    task automatic send_pixel(input logic [23:0] d, input bit fs_mid, output int l, output int w);
        l = -1;
        w = -1;
        pix_data = d;
        req = ~req;
        pix_ctrl[CTRL_REQ] = req;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_clk); #1;
            if (fs_mid && c == 1) pix_ctrl[CTRL_FS] = 1'b1;
            if (ram_write && w < 0) w = c;
            if (pix_status[ST_ACK] == req) begin
                l = c;
                break;
            end
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        pix_data      = '0;
        pix_ctrl      = '0;
        ram_readdata  = '0;
        repeat (3) @(posedge clk_clk);
        #1;
        check("rst_status", 32'(pix_status), 32'h0);
        check("rst_row", 32'(pix_row), 32'h0);
        check("rst_addr", 32'(ram_address), 32'h0);
        check("rst_strobes", 32'({ram_clken, ram_chipselect, ram_write}), 32'h0);
        check("rst_be", 32'(ram_byteenable), 32'h0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;

        // First pixel
        send_pixel(24'hA1B2C3, 1'b0, lat, wcyc);
        check("p0_latency", 32'(lat), 32'(LAT));
        check("p0_wr_cycle", 32'(wcyc), 32'd2);
        check("p0_wr_count", 32'(wr_count), 32'd1);
        check("p0_addr", 32'(last_addr), 32'h0);
        check("p0_data", last_data, 32'h00A1B2C3);
        check("p0_be", 32'(last_be), 32'h7);
        check("p0_ack", 32'(pix_status[ST_ACK]), 32'h1);
        check("p0_busy", 32'(pix_status[ST_BUSY]), 32'h0);

        // Rest of row 0, then first pixel of row 1
        for (int p = 1; p < 16; p++) send_pixel(24'(p), 1'b0, lat, wcyc);
        check("row0_last_addr", 32'(last_addr), 32'd15);
        check("row0_row", 32'(pix_row), 32'd1);
        send_pixel(24'h00BEEF, 1'b0, lat, wcyc);
        check("row1_first_addr", 32'(last_addr), 32'd16);
        check("row1_first_data", last_data, 32'h0000BEEF);

        // Complete the frame, then overflow with one extra pixel
        for (int p = 17; p < 64; p++) send_pixel(24'(p), 1'b0, lat, wcyc);
        check("frame_last_addr", 32'(last_addr), 32'd63);
        check("frame_done", 32'(pix_status[ST_DONE]), 32'h1);
        check("frame_row", 32'(pix_row), 32'd4);
        check("frame_err", 32'(pix_status[ST_ERR]), 32'h0);
        check("wr_total", 32'(wr_count), 32'd64);
        send_pixel(24'hFFFFFF, 1'b0, lat, wcyc);
        check("ovf_latency", 32'(lat), 32'd3);
        check("ovf_no_write", 32'(wr_count), 32'd64);
        check("ovf_err", 32'(pix_status[ST_ERR]), 32'h1);
        check("ovf_busy", 32'(pix_status[ST_BUSY]), 32'h0);

        // frame_start in IDLE clears error, done and counters
        pix_ctrl[CTRL_FS] = 1'b1;
        @(posedge clk_clk); #1;
        @(posedge clk_clk); #1;
        check("fs_err_clr", 32'(pix_status[ST_ERR]), 32'h0);
        check("fs_done_clr", 32'(pix_status[ST_DONE]), 32'h0);
        check("fs_row_clr", 32'(pix_row), 32'h0);
        check("fs_addr_clr", 32'(ram_address), 32'h0);
        pix_ctrl[CTRL_FS] = 1'b0;
        @(posedge clk_clk); #1;

        // frame_start arriving during WRITE is deferred until the pixel is acked
        for (int p = 0; p < 3; p++) send_pixel(24'h100 + 24'(p), 1'b0, lat, wcyc);
        send_pixel(24'h5A5A5A, 1'b1, lat, wcyc);
        check("fsmid_latency", 32'(lat), 32'(LAT));
        check("fsmid_addr", 32'(last_addr), 32'd3);
        check("fsmid_data", last_data, 32'h005A5A5A);
        @(posedge clk_clk); #1;
        check("fsmid_addr_clr", 32'(ram_address), 32'h0);
        pix_ctrl[CTRL_FS] = 1'b0;
        @(posedge clk_clk); #1;
        send_pixel(24'h0F0F0F, 1'b0, lat, wcyc);
        check("fsmid_next_addr", 32'(last_addr), 32'h0);
        check("fsmid_next_data", last_data, 32'h000F0F0F);

`ifdef PIXEL_LOADER_READBACK_EN
        check("rb_err_clean", 32'(pix_status[ST_ERR]), 32'h0);
        corrupt = 1'b1;
        send_pixel(24'h333333, 1'b0, lat, wcyc);
        corrupt = 1'b0;
        check("rb_latency", 32'(lat), 32'd6);
        check("rb_err", 32'(pix_status[ST_ERR]), 32'h1);
        check("rb_addr_adv", 32'(ram_address), 32'd2);
`else
        check("no_reads", 32'(rd_count), 32'h0);
`endif

        // Reset asserted while the write strobe is high
        pix_data = 24'h777777;
        req = ~req;
        pix_ctrl[CTRL_REQ] = req;
        @(posedge clk_clk);
        @(posedge clk_clk); #1;
        check("rstw_strobe_pre", 32'(ram_write), 32'h1);
        wc_before = wr_count;
        #1 reset_reset_n = 1'b0;
        #1;
        check("rstw_strobes", 32'({ram_clken, ram_chipselect, ram_write}), 32'h0);
        check("rstw_status", 32'(pix_status), 32'h0);
        check("rstw_row", 32'(pix_row), 32'h0);
        check("rstw_addr", 32'(ram_address), 32'h0);
        pix_ctrl = '0;
        req = 1'b0;
        @(posedge clk_clk);
        check("rstw_no_write", 32'(wr_count), 32'(wc_before));
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        send_pixel(24'h123456, 1'b0, lat, wcyc);
        check("rstw_after_count", 32'(wr_count), 32'(wc_before + 1));
        check("rstw_after_addr", 32'(last_addr), 32'h0);
        check("rstw_after_data", last_data, 32'h00123456);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
